// File: rtl/alu_arbiter_if.sv
// Requester and ALU-facing signals of the two-port ALU arbiter.
// The master side is the environment (both requesters plus the ALU); the slave side is the arbiter.
interface alu_arbiter_if #(
  parameter int NBIT = 32,
  parameter int OPW  = 4
);

  logic            req_valid_0;
  logic            req_ready_0;
  logic [OPW-1:0]  req_op_0;
  logic [NBIT-1:0] req_a_0;
  logic [NBIT-1:0] req_b_0;
  logic            rsp_valid_0;
  logic            rsp_ready_0;

  logic            req_valid_1;
  logic            req_ready_1;
  logic [OPW-1:0]  req_op_1;
  logic [NBIT-1:0] req_a_1;
  logic [NBIT-1:0] req_b_1;
  logic            rsp_valid_1;
  logic            rsp_ready_1;

  logic [NBIT-1:0] rsp_data;

  logic [OPW-1:0]  alu_op;
  logic [NBIT-1:0] alu_in_a;
  logic [NBIT-1:0] alu_in_b;
  logic [NBIT-1:0] alu_out;

  modport master (
    output req_valid_0, req_op_0, req_a_0, req_b_0, rsp_ready_0,
    output req_valid_1, req_op_1, req_a_1, req_b_1, rsp_ready_1,
    output alu_out,
    input  req_ready_0, rsp_valid_0, req_ready_1, rsp_valid_1,
    input  rsp_data, alu_op, alu_in_a, alu_in_b
  );

  modport slave (
    input  req_valid_0, req_op_0, req_a_0, req_b_0, rsp_ready_0,
    input  req_valid_1, req_op_1, req_a_1, req_b_1, rsp_ready_1,
    input  alu_out,
    output req_ready_0, rsp_valid_0, req_ready_1, rsp_valid_1,
    output rsp_data, alu_op, alu_in_a, alu_in_b
  );

endinterface

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational DLX ALU between the execute stage (port 0)
// and the address/branch unit (port 1); operands are registered in, the result is held until consumed.
module alu_arbiter #(
  parameter int NBIT = 32,
  parameter int OPW  = 4
) (
  input  logic          clk,
  input  logic          rst,
  alu_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

  state_e          state_q,    state_d;
  logic            rr_ptr_q,   rr_ptr_d;
  logic            grant_q,    grant_d;
  logic [OPW-1:0]  alu_op_q,   alu_op_d;
  logic [NBIT-1:0] alu_in_a_q, alu_in_a_d;
  logic [NBIT-1:0] alu_in_b_q, alu_in_b_d;
  logic [NBIT-1:0] rsp_data_q, rsp_data_d;

  logic any_valid;
  logic sel_port;
  logic req_ready_0;
  logic req_ready_1;
  logic accept;
  logic rsp_ready_sel;

  // With both ports valid the pointer decides; otherwise the lone valid port wins.
  always_comb begin
    any_valid     = bus.req_valid_0 | bus.req_valid_1;
    sel_port      = (bus.req_valid_0 && bus.req_valid_1) ? rr_ptr_q : bus.req_valid_1;
    req_ready_0   = !rst && (state_q == IDLE) && any_valid && !sel_port;
    req_ready_1   = !rst && (state_q == IDLE) && any_valid &&  sel_port;
    accept        = req_ready_0 | req_ready_1;
    rsp_ready_sel = grant_q ? bus.rsp_ready_1 : bus.rsp_ready_0;
  end

  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    grant_d    = grant_q;
    alu_op_d   = alu_op_q;
    alu_in_a_d = alu_in_a_q;
    alu_in_b_d = alu_in_b_q;
    rsp_data_d = rsp_data_q;

    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d  = EXEC;
          grant_d  = sel_port;
          rr_ptr_d = ~sel_port;
          if (sel_port) begin
            alu_op_d   = bus.req_op_1;
            alu_in_a_d = bus.req_a_1;
            alu_in_b_d = bus.req_b_1;
          end else begin
            alu_op_d   = bus.req_op_0;
            alu_in_a_d = bus.req_a_0;
            alu_in_b_d = bus.req_b_0;
          end
        end
      end

      // The ALU has had a full cycle to settle on the registered operands.
      EXEC: begin
        rsp_data_d = bus.alu_out;
        state_d    = RESP;
      end

      RESP: begin
        if (rsp_ready_sel) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      rr_ptr_q   <= 1'b0;
      grant_q    <= 1'b0;
      alu_op_q   <= '0;
      alu_in_a_q <= '0;
      alu_in_b_q <= '0;
      rsp_data_q <= '0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      grant_q    <= grant_d;
      alu_op_q   <= alu_op_d;
      alu_in_a_q <= alu_in_a_d;
      alu_in_b_q <= alu_in_b_d;
      rsp_data_q <= rsp_data_d;
    end
  end

  // Response valids come straight from registered state, so they are glitch-free.
  assign bus.req_ready_0 = req_ready_0;
  assign bus.req_ready_1 = req_ready_1;
  assign bus.rsp_valid_0 = (state_q == RESP) && !grant_q;
  assign bus.rsp_valid_1 = (state_q == RESP) &&  grant_q;
  assign bus.rsp_data    = rsp_data_q;
  assign bus.alu_op      = alu_op_q;
  assign bus.alu_in_a    = alu_in_a_q;
  assign bus.alu_in_b    = alu_in_b_q;

endmodule
